frame_timing_gen: RTL and testbench

- Camera-link style sync generator sitting directly upstream of the pattern generator.
- Produces fval, lval and dval framing, plus the single-cycle fval_posedge and lval_negedge strobes the pattern stage consumes.
- Frame geometry matches the pattern stage parameters (DVAL_HIGH pixels × ROW_COUNT lines), with programmable blanking.
- Supports single-shot and free-running frame modes.

---
 rtl/frame_pkg.sv | 32 +++
 rtl/frame_timing_gen_sync_edge_strobe.sv | 30 +++
 rtl/frame_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_frame_timing_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Framing definitions shared by the sync generator and the downstream pattern stage,
// so both sides agree on line length and line count.
package frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FV_SETUP    = 3'd1,
        ST_LINE_ACTIVE = 3'd2,
        ST_LINE_BLANK  = 3'd3,
        ST_FV_HOLD     = 3'd4,
        ST_V_BLANK     = 3'd5
    } state_t;

    localparam int DEF_DVAL_HIGH = 640;
    localparam int DEF_ROW_COUNT = 480;
    localparam int DEF_H_BLANK   = 16;
    localparam int DEF_FV_TO_LV  = 4;
    localparam int DEF_LV_TO_FV  = 4;
    localparam int DEF_V_BLANK   = 32;
    localparam int DEF_CNT_W     = 16;

    // fval is asserted from frame setup through the post-line hold
    function automatic logic fval_state(input state_t s);
        logic r;
        case (s)
            ST_FV_SETUP, ST_LINE_ACTIVE, ST_LINE_BLANK, ST_FV_HOLD: r = 1'b1;
            default:                                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/frame_timing_gen_sync_edge_strobe.sv
// Registered level plus single-cycle edge strobe; the strobe lines up with the first
// cycle the registered level shows the new value.
module sync_edge_strobe #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic strobe
);

    logic level_r;
    logic strobe_r;

    // register the level and compare the incoming value against it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r  <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            level_r  <= d;
            strobe_r <= RISING ? (d & ~level_r) : (~d & level_r);
        end
    end

    assign level  = level_r;
    assign strobe = strobe_r;

endmodule

// File: rtl/frame_timing_gen.sv
// Camera-link style fval/lval/dval generator with single-shot and free-running frames.
// Outputs are registered from the next state so they line up with the state they describe.
module frame_timing_gen
    import frame_pkg::*;
#(
    parameter int DVAL_HIGH = DEF_DVAL_HIGH,
    parameter int ROW_COUNT = DEF_ROW_COUNT,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int FV_TO_LV  = DEF_FV_TO_LV,
    parameter int LV_TO_FV  = DEF_LV_TO_FV,
    parameter int V_BLANK   = DEF_V_BLANK,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             continuous,
    output logic             fval,
    output logic             lval,
    output logic             dval,
    output logic             fval_posedge,
    output logic             lval_negedge,
    output logic             frame_done,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] DVAL_LAST  = CNT_W'(DVAL_HIGH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_COUNT - 1);
    localparam logic [CNT_W-1:0] HBLK_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(FV_TO_LV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(LV_TO_FV - 1);
    localparam logic [CNT_W-1:0] VBLK_LAST  = CNT_W'(V_BLANK - 1);

    state_t           state_r;
    state_t           state_s;
    logic             last_s;
    logic [CNT_W-1:0] cyc_r;
    logic [CNT_W-1:0] line_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             frame_done_r;
    logic             busy_r;
    logic             fval_s;
    logic             lval_s;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state decode; last_s marks the final cycle of the current state
    always_comb begin
        state_s = state_r;
        last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && enable) state_s = ST_FV_SETUP;
                else                 state_s = ST_IDLE;
            end
            ST_FV_SETUP: begin
                last_s = (cyc_r == SETUP_LAST);
                if (last_s) state_s = ST_LINE_ACTIVE;
                else        state_s = ST_FV_SETUP;
            end
            ST_LINE_ACTIVE: begin
                last_s = (cyc_r == DVAL_LAST);
                if (last_s) begin
                    if (line_r == ROW_LAST) state_s = ST_FV_HOLD;
                    else                    state_s = ST_LINE_BLANK;
                end else begin
                    state_s = ST_LINE_ACTIVE;
                end
            end
            ST_LINE_BLANK: begin
                last_s = (cyc_r == HBLK_LAST);
                if (last_s) state_s = ST_LINE_ACTIVE;
                else        state_s = ST_LINE_BLANK;
            end
            ST_FV_HOLD: begin
                last_s = (cyc_r == HOLD_LAST);
                if (last_s) begin
                    if (continuous && enable) state_s = ST_V_BLANK;
                    else                      state_s = ST_IDLE;
                end else begin
                    state_s = ST_FV_HOLD;
                end
            end
            ST_V_BLANK: begin
                last_s = (cyc_r == VBLK_LAST);
                if (last_s) begin
                    if (enable) state_s = ST_FV_SETUP;
                    else        state_s = ST_IDLE;
                end else begin
                    state_s = ST_V_BLANK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // per-state cycle counter, restarted on every state entry and parked in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_r <= '0;
        end else if ((state_s != state_r) || (state_s == ST_IDLE)) begin
            cyc_r <= '0;
        end else begin
            cyc_r <= cyc_r + CNT_W'(1);
        end
    end

    // completed-line counter within the current frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_r <= '0;
        end else if ((state_r == ST_LINE_ACTIVE) && last_s) begin
            line_r <= line_r + CNT_W'(1);
        end else if (state_s == ST_FV_SETUP) begin
            line_r <= '0;
        end else begin
            line_r <= line_r;
        end
    end

    // frame completion: count and pulse land in the first cycle fval is low again
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r  <= '0;
            frame_done_r <= 1'b0;
        end else if ((state_r == ST_FV_HOLD) && last_s) begin
            frame_cnt_r  <= frame_cnt_r + CNT_W'(1);
            frame_done_r <= 1'b1;
        end else begin
            frame_cnt_r  <= frame_cnt_r;
            frame_done_r <= 1'b0;
        end
    end

    // busy flag registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign fval_s = fval_state(state_s);
    assign lval_s = (state_s == ST_LINE_ACTIVE);

    sync_edge_strobe #(.RISING(1'b1)) u_fval_edge (
        .clk    (clk),
        .rst    (rst),
        .d      (fval_s),
        .level  (fval),
        .strobe (fval_posedge)
    );

    sync_edge_strobe #(.RISING(1'b0)) u_lval_edge (
        .clk    (clk),
        .rst    (rst),
        .d      (lval_s),
        .level  (lval),
        .strobe (lval_negedge)
    );

    // pixels are gapless, so data valid follows line valid
    assign dval       = lval;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Bench for frame_timing_gen: frame-level reference model checked every cycle, directed
// scenarios pinned against hand-computed cycle positions, then randomized stimulus.
`timescale 1ns/1ps
module tb_frame_timing_gen;

    localparam int DV = 4, ROWS = 3, HB = 2, FL = 2, LF = 2, VB = 3;
    localparam int ACTIVE = FL + ROWS * DV + (ROWS - 1) * HB + LF;

    typedef struct {
        bit in_frame;
        bit in_vb;
        int p;
        int frames;
        bit fval, lval, busy, pe, ne, fd;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0, start = 1'b0, continuous = 1'b0;
    logic fval, lval, dval, fval_posedge, lval_negedge, frame_done, busy;
    logic [7:0] frame_cnt;
    logic b_fval, b_lval, b_dval, b_pe, b_ne, b_fd, b_busy;
    logic [1:0] b_cnt;
    int n_checks = 0;
    int n_fail = 0;
    mdl_t mdl;

    frame_timing_gen #(.DVAL_HIGH(DV), .ROW_COUNT(ROWS), .H_BLANK(HB), .FV_TO_LV(FL),
                       .LV_TO_FV(LF), .V_BLANK(VB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .continuous(continuous),
        .fval(fval), .lval(lval), .dval(dval), .fval_posedge(fval_posedge),
        .lval_negedge(lval_negedge), .frame_done(frame_done), .busy(busy),
        .frame_cnt(frame_cnt));

    frame_timing_gen #(.DVAL_HIGH(DV), .ROW_COUNT(ROWS), .H_BLANK(HB), .FV_TO_LV(FL),
                       .LV_TO_FV(LF), .V_BLANK(VB), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .continuous(continuous),
        .fval(b_fval), .lval(b_lval), .dval(b_dval), .fval_posedge(b_pe),
        .lval_negedge(b_ne), .frame_done(b_fd), .busy(b_busy), .frame_cnt(b_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_zero();
        mdl_t m;
        m.in_frame = 1'b0; m.in_vb = 1'b0; m.p = 0; m.frames = 0;
        m.fval = 1'b0; m.lval = 1'b0; m.busy = 1'b0; m.pe = 1'b0; m.ne = 1'b0; m.fd = 1'b0;
        return m;
    endfunction

    // is offset p (0 = first fval cycle) inside an active line?
    function automatic bit lval_at(input int p);
        int q = p - FL;
        return (q >= 0) && (q < ROWS * (DV + HB) - HB) && ((q % (DV + HB)) < DV);
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit st, input bit en, input bit co);
        mdl_t n = m;
        if (m.in_frame) begin
            if (m.p == ACTIVE - 1) begin
                n.frames = m.frames + 1; n.in_frame = 1'b0; n.in_vb = co && en; n.p = 0;
            end else begin
                n.p = m.p + 1;
            end
        end else if (m.in_vb) begin
            if (m.p == VB - 1) begin
                n.in_vb = 1'b0; n.in_frame = en; n.p = 0;
            end else begin
                n.p = m.p + 1;
            end
        end else if (st && en) begin
            n.in_frame = 1'b1; n.p = 0;
        end
        n.fval = n.in_frame;
        n.lval = n.in_frame && lval_at(n.p);
        n.busy = n.in_frame || n.in_vb;
        n.pe = n.fval && !m.fval;
        n.fd = !n.fval && m.fval;
        n.ne = !n.lval && m.lval;
        return n;
    endfunction

    // reference model advances on the same edge the DUT samples its inputs
    always @(posedge clk or negedge rst) begin
        if (!rst) mdl <= mdl_zero();
        else      mdl <= step(mdl, start, enable, continuous);
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("fval", fval, mdl.fval);
        chk("lval", lval, mdl.lval);
        chk("dval", dval, mdl.lval);
        chk("fval_posedge", fval_posedge, mdl.pe);
        chk("lval_negedge", lval_negedge, mdl.ne);
        chk("frame_done", frame_done, mdl.fd);
        chk("busy", busy, mdl.busy);
        chk("frame_cnt", frame_cnt, 64'(mdl.frames % 256));
        chk("w2_fval", b_fval, mdl.fval);
        chk("w2_lval", b_lval, mdl.lval);
        chk("w2_dval", b_dval, mdl.lval);
        chk("w2_fval_posedge", b_pe, mdl.pe);
        chk("w2_lval_negedge", b_ne, mdl.ne);
        chk("w2_frame_done", b_fd, mdl.fd);
        chk("w2_busy", b_busy, mdl.busy);
        chk("w2_frame_cnt", b_cnt, 64'(mdl.frames % 4));
    end

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] frame_lv(input int b);
        return rng(b + 2, b + 5) | rng(b + 8, b + 11) | rng(b + 14, b + 17);
    endfunction

    function automatic logic [63:0] frame_ne(input int b);
        return rng(b + 6, b + 6) | rng(b + 12, b + 12) | rng(b + 18, b + 18);
    endfunction

    // start a frame now (called at a negedge) and record event positions by offset
    task automatic run_seq(input bit cont, input int s2, input int en_off, input int c_off,
                           input int n, output logic [63:0] fv, output logic [63:0] lv,
                           output logic [63:0] pe, output logic [63:0] ne,
                           output logic [63:0] fd, output logic [63:0] bz);
        fv = '0; lv = '0; pe = '0; ne = '0; fd = '0; bz = '0;
        enable = 1'b1; continuous = cont; start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            fv[k] = fval; lv[k] = lval; pe[k] = fval_posedge;
            ne[k] = lval_negedge; fd[k] = frame_done; bz[k] = busy;
            start = (k == s2);
            if (k == en_off) enable = 1'b0;
            if (k == c_off) continuous = 1'b0;
        end
        start = 1'b0; continuous = 1'b0; enable = 1'b1;
    endtask

    task automatic check_single(input string tag, input logic [63:0] fv, input logic [63:0] lv,
                                input logic [63:0] pe, input logic [63:0] ne,
                                input logic [63:0] fd, input logic [63:0] bz);
        chk({tag, "_fval"}, fv, rng(1, 20));
        chk({tag, "_lval"}, lv, frame_lv(1));
        chk({tag, "_posedge"}, pe, rng(1, 1));
        chk({tag, "_negedge"}, ne, frame_ne(1));
        chk({tag, "_done"}, fd, rng(21, 21));
        chk({tag, "_busy"}, bz, rng(1, 20));
    endtask

    logic [63:0] fv, lv, pe, ne, fd, bz;
    logic [1:0] seq [5];

    initial begin
        int got;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_fval", fval, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cnt", frame_cnt, 8'd0);
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);

        // single shot
        run_seq(1'b0, -1, -1, -1, 30, fv, lv, pe, ne, fd, bz);
        check_single("single", fv, lv, pe, ne, fd, bz);
        chk("single_cnt", frame_cnt, 8'd1);
        repeat (3) @(negedge clk);

        // second start while busy is dropped
        run_seq(1'b0, 5, -1, -1, 30, fv, lv, pe, ne, fd, bz);
        check_single("dupstart", fv, lv, pe, ne, fd, bz);
        chk("dupstart_cnt", frame_cnt, 8'd2);
        repeat (3) @(negedge clk);

        // continuous for two frames, period 23
        run_seq(1'b1, -1, -1, 30, 50, fv, lv, pe, ne, fd, bz);
        chk("cont_fval", fv, rng(1, 20) | rng(24, 43));
        chk("cont_lval", lv, frame_lv(1) | frame_lv(24));
        chk("cont_posedge", pe, rng(1, 1) | rng(24, 24));
        chk("cont_negedge", ne, frame_ne(1) | frame_ne(24));
        chk("cont_done", fd, rng(21, 21) | rng(44, 44));
        chk("cont_busy", bz, rng(1, 43));
        chk("cont_cnt", frame_cnt, 8'd4);
        repeat (3) @(negedge clk);

        // enable dropped mid-frame in continuous mode
        run_seq(1'b1, -1, 10, -1, 30, fv, lv, pe, ne, fd, bz);
        check_single("endrop", fv, lv, pe, ne, fd, bz);
        chk("endrop_cnt", frame_cnt, 8'd5);
        repeat (3) @(negedge clk);

        // reset mid-line
        enable = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        chk("rstmid_pre_lval", lval, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("rstmid_fval", fval, 1'b0);
        chk("rstmid_lval", lval, 1'b0);
        chk("rstmid_dval", dval, 1'b0);
        chk("rstmid_strobes", {fval_posedge, lval_negedge, frame_done}, 3'b000);
        chk("rstmid_cnt", frame_cnt, 8'd0);
        @(negedge clk); #1 rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstmid_after_busy", busy, 1'b0);

        // 2-bit frame counter wraps over five continuous frames
        enable = 1'b1; continuous = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        got = 0;
        for (int k = 0; k < 200 && got < 5; k++) begin
            @(negedge clk);
            if (b_fd) begin
                seq[got] = b_cnt;
                got++;
                if (got == 5) begin continuous = 1'b0; enable = 1'b0; end
            end
        end
        chk("wrap_frames_seen", got, 5);
        if (got == 5) begin
            chk("wrap_seq0", seq[0], 2'd1);
            chk("wrap_seq1", seq[1], 2'd2);
            chk("wrap_seq2", seq[2], 2'd3);
            chk("wrap_seq3", seq[3], 2'd0);
            chk("wrap_seq4", seq[4], 2'd1);
        end
        repeat (6) @(negedge clk);
        enable = 1'b1;

        // randomized phase, model checked every cycle
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) continuous = ~continuous;
            if ($urandom_range(0, 699) == 0) begin
                #1 rst = 1'b0;
                @(negedge clk);
                #1 rst = 1'b1;
            end
        end

        start = 1'b0; continuous = 1'b0; enable = 1'b0;
        got = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            @(negedge clk);
            got = k;
        end
        chk("drain_idle", busy, 1'b0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
